audio_cqueue: RTL

- Circular stereo sample queue directly downstream of the codec interface.
- Captures each left/right sample pair delivered by the codec.
- Once primed, replays the most recent SEQ_LEN pairs oldest-to-newest, one pair per clock, after every new write.
- Feeds the FIR/equalizer datapath, which consumes one pair per cycle while sequencing is high.

---
 rtl/audio_cqueue_if.sv | 32 +++
 rtl/audio_cqueue.sv | 120 ++++++++++++
 2 files changed

// File: rtl/audio_cqueue_if.sv
`default_nettype none
// ============================================================================
// Module  : audio_cqueue_if
// Brief   : Codec-side write port and replay output bundle for audio_cqueue.
//           Optional overrun flag present with CQ_OVERRUN_DET_EN.
// Revision: 1.0
// ============================================================================
interface audio_cqueue_if #(
    parameter int DW = 16
);
    logic          wrt_smpl;
    logic [DW-1:0] lft_smpl;
    logic [DW-1:0] rht_smpl;
    logic [DW-1:0] lft_out;
    logic [DW-1:0] rht_out;
    logic          sequencing;
    logic          full;
`ifdef CQ_OVERRUN_DET_EN
    logic          overrun;

    modport master (output wrt_smpl, lft_smpl, rht_smpl,
                    input  lft_out, rht_out, sequencing, full, overrun);
    modport slave  (input  wrt_smpl, lft_smpl, rht_smpl,
                    output lft_out, rht_out, sequencing, full, overrun);
`else
    modport master (output wrt_smpl, lft_smpl, rht_smpl,
                    input  lft_out, rht_out, sequencing, full);
    modport slave  (input  wrt_smpl, lft_smpl, rht_smpl,
                    output lft_out, rht_out, sequencing, full);
`endif
endinterface
`default_nettype wire

// File: rtl/audio_cqueue.sv
`default_nettype none
// ============================================================================
// Module  : audio_cqueue
// Brief   : Circular stereo sample queue; after each write (once primed) it
//           replays the last SEQ_LEN pairs oldest-to-newest, one per clock.
//           Optional macro: CQ_OVERRUN_DET_EN (sticky overrun flag).
// Revision: 1.0
// ============================================================================
module audio_cqueue #(
    parameter int DEPTH   = 1024,
    parameter int SEQ_LEN = 1021,
    parameter int DW      = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    audio_cqueue_if.slave bus
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN + 1) : 1;

    // Start of window = new_ptr + 1 - SEQ_LEN, folded into one modulo constant
    localparam logic [c_AW-1:0] c_RD_OFS   = c_AW'(DEPTH + 1 - SEQ_LEN);
    localparam logic [c_CW-1:0] c_LAST     = c_CW'(SEQ_LEN - 1);
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(SEQ_LEN);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEQ  = 1'b1;

    logic [DW-1:0]   r_mem_lft [DEPTH];
    logic [DW-1:0]   r_mem_rht [DEPTH];
    logic [c_AW-1:0] r_new_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_seq_cnt;
    logic [c_CW-1:0] r_fill_cnt;
    logic [0:0]      r_state;
    logic            r_sequencing;
    logic [DW-1:0]   r_lft_out;
    logic [DW-1:0]   r_rht_out;

    logic w_full;
    logic w_rd_en;
    logic w_trigger;

    assign w_full    = (r_fill_cnt == c_FULL_CNT);
    assign w_rd_en   = (r_state == c_ST_SEQ);
    assign w_trigger = bus.wrt_smpl && (r_state == c_ST_IDLE) &&
                       (w_full || (r_fill_cnt == c_LAST));

    always_ff @(posedge clk) begin
        if (bus.wrt_smpl) begin
            r_mem_lft[r_new_ptr] <= bus.lft_smpl;
            r_mem_rht[r_new_ptr] <= bus.rht_smpl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_new_ptr  <= '0;
            r_rd_ptr   <= '0;
            r_seq_cnt  <= '0;
            r_fill_cnt <= '0;
            r_state    <= c_ST_IDLE;
        end else begin
            if (bus.wrt_smpl) begin
                r_new_ptr <= r_new_ptr + c_AW'(1);
                if (!w_full)
                    r_fill_cnt <= r_fill_cnt + c_CW'(1);
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_trigger) begin
                        r_rd_ptr  <= r_new_ptr + c_RD_OFS;
                        r_seq_cnt <= '0;
                        r_state   <= c_ST_SEQ;
                    end
                end
                default: begin
                    r_rd_ptr  <= r_rd_ptr + c_AW'(1);
                    r_seq_cnt <= r_seq_cnt + c_CW'(1);
                    if (r_seq_cnt == c_LAST)
                        r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Output registers double as the read pipeline stage; they hold between sequences
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sequencing <= 1'b0;
            r_lft_out    <= '0;
            r_rht_out    <= '0;
        end else begin
            r_sequencing <= w_rd_en;
            if (w_rd_en) begin
                r_lft_out <= r_mem_lft[r_rd_ptr];
                r_rht_out <= r_mem_rht[r_rd_ptr];
            end
        end
    end

    assign bus.lft_out    = r_lft_out;
    assign bus.rht_out    = r_rht_out;
    assign bus.sequencing = r_sequencing;
    assign bus.full       = w_full;

`ifdef CQ_OVERRUN_DET_EN
    logic r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_overrun <= 1'b0;
        else if (bus.wrt_smpl && (r_state == c_ST_SEQ))
            r_overrun <= 1'b1;
    end

    assign bus.overrun = r_overrun;
`endif
endmodule
`default_nettype wire
